// File: rtl/sqrt_batch_pkg.sv
// Shared types and constants for the square-root batch bus master.
// Accelerator register offsets are relative to the ACCEL_BASE parameter of the top.
package sqrt_batch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        WR_ACC,
        WAIT_BUSY,
        WAIT_IDLE,
        RD_RES,
        WR_DST,
        FINISH
    } state_t;

    localparam logic [31:0] OFF_IN   = 32'h0;
    localparam logic [31:0] OFF_RES  = 32'h4;
    localparam logic [31:0] OFF_STAT = 32'h8;
    localparam int          STAT_BIT = 0;

endpackage

// File: rtl/sqrt_batch_master_poll_timer.sv
// Cycle counter bounding how long the master may sit in one status-poll state.
// Saturates once expired so a stuck slave cannot wrap it back to zero.
module poll_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // expired marks the TIMEOUT-th cycle spent polling
    assign expired = en && (cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sqrt_batch_master.sv
// Second bus master that streams radicands through the square-root accelerator
// and writes each root back to memory without CPU involvement.
module sqrt_batch_master
    import sqrt_batch_pkg::*;
#(
    parameter logic [31:0] ACCEL_BASE = 32'h0000_0000,
    parameter int          TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [31:0] cmd_src,
    input  logic [31:0] cmd_dst,
    input  logic [15:0] cmd_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] processed,
    output logic        m_cs,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    state_t      state, next_state;
    logic [31:0] src_ptr, dst_ptr, data_reg;
    logic [15:0] remaining;
    logic        expired, timed_out, poll_en;

    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign poll_en = (state == WAIT_BUSY) || (state == WAIT_IDLE);

    // The timer restarts on every state change, so each WAIT state gets a fresh budget
    poll_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (next_state != state),
        .en      (poll_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus outputs depend only on state and registers; m_rdata only steers next_state
    always_comb begin
        next_state = state;
        timed_out  = 1'b0;
        m_cs       = 1'b0;
        m_we       = 1'b0;
        m_addr     = 32'h0;
        m_wdata    = 32'h0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    next_state = (cmd_count == 16'd0) ? FINISH : RD_SRC;
                end
            end
            RD_SRC: begin
                m_cs       = 1'b1;
                m_addr     = src_ptr;
                next_state = WR_ACC;
            end
            WR_ACC: begin
                m_cs       = 1'b1;
                m_we       = 1'b1;
                m_addr     = ACCEL_BASE + OFF_IN;
                m_wdata    = data_reg;
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                m_cs   = 1'b1;
                m_addr = ACCEL_BASE + OFF_STAT;
                if (m_rdata[STAT_BIT]) begin
                    next_state = WAIT_IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = FINISH;
                end
            end
            WAIT_IDLE: begin
                m_cs   = 1'b1;
                m_addr = ACCEL_BASE + OFF_STAT;
                if (!m_rdata[STAT_BIT]) begin
                    next_state = RD_RES;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = FINISH;
                end
            end
            RD_RES: begin
                m_cs       = 1'b1;
                m_addr     = ACCEL_BASE + OFF_RES;
                next_state = WR_DST;
            end
            WR_DST: begin
                m_cs       = 1'b1;
                m_we       = 1'b1;
                m_addr     = dst_ptr;
                m_wdata    = data_reg;
                next_state = (remaining == 16'd1) ? FINISH : RD_SRC;
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // data_reg carries the radicand into the accelerator and later the root out to memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr   <= 32'h0;
            dst_ptr   <= 32'h0;
            data_reg  <= 32'h0;
            remaining <= 16'h0;
            processed <= 16'h0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        src_ptr   <= cmd_src & ~32'h3;
                        dst_ptr   <= cmd_dst & ~32'h3;
                        remaining <= cmd_count;
                        processed <= 16'h0;
                        err       <= 1'b0;
                    end
                end
                RD_SRC, RD_RES: begin
                    data_reg <= m_rdata;
                end
                WAIT_BUSY, WAIT_IDLE: begin
                    if (timed_out) begin
                        err <= 1'b1;
                    end
                end
                WR_DST: begin
                    src_ptr   <= src_ptr + 32'd4;
                    dst_ptr   <= dst_ptr + 32'd4;
                    processed <= processed + 16'd1;
                    remaining <= remaining - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
